// File: rtl/fft_pkg.sv
// Shared types and constants for the post-FFT spectral detection path.
// Contents: frame geometry (N_BINS, BIN_IDX_W), sample/power widths
// (DATA_W, MAG_W), complex bin and power types, frame FSM state encoding.
package fft_pkg;

    localparam int N_BINS    = 32;
    localparam int DATA_W    = 32;
    localparam int BIN_IDX_W = $clog2(N_BINS);
    localparam int MAG_W     = 2 * DATA_W;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef logic [MAG_W-1:0]     mag_t;
    typedef logic [BIN_IDX_W-1:0] bin_idx_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } frame_state_e;

endpackage

// File: rtl/fft_peak_bin_detector_if.sv
// Bus between the FFT bin stream and the peak detector.
// master: drives bin_real/bin_imag/bin_valid/bin_sof, observes results.
// slave : consumes the bin stream, drives peak_valid/peak_bin/peak_mag/frame_err.
interface fft_peak_bin_detector_if;
    import fft_pkg::*;

    logic signed [DATA_W-1:0] bin_real;
    logic signed [DATA_W-1:0] bin_imag;
    logic                     bin_valid;
    logic                     bin_sof;
    logic                     peak_valid;
    bin_idx_t                 peak_bin;
    mag_t                     peak_mag;
    logic                     frame_err;

    modport master (
        output bin_real, bin_imag, bin_valid, bin_sof,
        input  peak_valid, peak_bin, peak_mag, frame_err
    );

    modport slave (
        input  bin_real, bin_imag, bin_valid, bin_sof,
        output peak_valid, peak_bin, peak_mag, frame_err
    );
endinterface

// File: rtl/cplx_mag_sq.sv
// Two-stage |X|^2 pipeline: P1 registers re^2 and im^2, P2 registers their sum.
// Bin index and first/last tags ride alongside so the consumer sees them
// aligned with the power value.
// Ports: clk, reset (async active-low), in_* (valid, bin, idx, first, last),
//        out_* (valid, mag, idx, first, last).
module cplx_mag_sq
    import fft_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid,
    input  cplx_t    in_bin,
    input  bin_idx_t in_idx,
    input  logic     in_first,
    input  logic     in_last,
    output logic     out_valid,
    output mag_t     out_mag,
    output bin_idx_t out_idx,
    output logic     out_first,
    output logic     out_last
);

    logic signed [MAG_W-1:0] re_ext, im_ext;
    mag_t     re_sq_d, im_sq_d, re_sq_q, im_sq_q;
    logic     p1_valid_q, p1_first_q, p1_last_q;
    bin_idx_t p1_idx_q;
    mag_t     mag_d, mag_q;
    logic     p2_valid_q, p2_first_q, p2_last_q;
    bin_idx_t p2_idx_q;

    // Squares are non-negative and at most 2^(2*DATA_W-2), so the unsigned
    // sum of both cannot exceed 2^(2*DATA_W-1) and never wraps.
    always_comb begin
        re_ext  = MAG_W'($signed(in_bin.re));
        im_ext  = MAG_W'($signed(in_bin.im));
        re_sq_d = mag_t'(re_ext * re_ext);
        im_sq_d = mag_t'(im_ext * im_ext);
        mag_d   = re_sq_q + im_sq_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_valid_q <= 1'b0;
            p1_first_q <= 1'b0;
            p1_last_q  <= 1'b0;
            p1_idx_q   <= '0;
            re_sq_q    <= '0;
            im_sq_q    <= '0;
            p2_valid_q <= 1'b0;
            p2_first_q <= 1'b0;
            p2_last_q  <= 1'b0;
            p2_idx_q   <= '0;
            mag_q      <= '0;
        end else begin
            p1_valid_q <= in_valid;
            p1_first_q <= in_first;
            p1_last_q  <= in_last;
            p1_idx_q   <= in_idx;
            re_sq_q    <= re_sq_d;
            im_sq_q    <= im_sq_d;
            p2_valid_q <= p1_valid_q;
            p2_first_q <= p1_first_q;
            p2_last_q  <= p1_last_q;
            p2_idx_q   <= p1_idx_q;
            mag_q      <= mag_d;
        end
    end

    assign out_valid = p2_valid_q;
    assign out_mag   = mag_q;
    assign out_idx   = p2_idx_q;
    assign out_first = p2_first_q;
    assign out_last  = p2_last_q;

endmodule

// File: rtl/fft_peak_bin_detector.sv
// Per-frame peak search over the streamed FFT bins.
// Ports: clk, reset (async active-low), bus (slave modport): bin stream in,
//        peak_valid/peak_bin/peak_mag/frame_err out.
// Parameter SKIP_DC: 1 excludes bin 0 from the peak search.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | between frames, waiting for a beat flagged bin_sof
//   ST_ACCUM | inside a frame, bin_cnt_q is the index of the next beat
module fft_peak_bin_detector
    import fft_pkg::*;
#(
    parameter bit SKIP_DC = 1'b0
) (
    input logic                     clk,
    input logic                     reset,
    fft_peak_bin_detector_if.slave  bus
);

    frame_state_e state_q, state_d;
    bin_idx_t     bin_cnt_q, bin_cnt_d;
    logic         frame_err_q, frame_err_d;

    logic     tag_valid, tag_first, tag_last;
    bin_idx_t tag_idx;
    cplx_t    in_bin;

    logic     m_valid, m_first, m_last;
    mag_t     m_mag;
    bin_idx_t m_idx;

    mag_t     max_mag_q, max_mag_d;
    bin_idx_t max_idx_q, max_idx_d;
    logic     peak_valid_q, peak_valid_d;
    bin_idx_t peak_bin_q, peak_bin_d;
    mag_t     peak_mag_q, peak_mag_d;
    logic     seed, eligible;

    assign in_bin = {bus.bin_real, bus.bin_imag};

    always_comb begin
        state_d     = state_q;
        bin_cnt_d   = bin_cnt_q;
        frame_err_d = 1'b0;
        tag_valid   = 1'b0;
        tag_idx     = bin_cnt_q;
        tag_first   = 1'b0;
        tag_last    = 1'b0;
        if (bus.bin_valid) begin
            if (bus.bin_sof) begin
                // An sof inside a frame abandons it; the beat restarts as bin 0.
                frame_err_d = (state_q == ST_ACCUM);
                tag_valid   = 1'b1;
                tag_idx     = '0;
                tag_first   = 1'b1;
                bin_cnt_d   = bin_idx_t'(1);
                state_d     = ST_ACCUM;
            end else if (state_q == ST_IDLE) begin
                frame_err_d = 1'b1;
            end else begin
                tag_valid = 1'b1;
                if (bin_cnt_q == bin_idx_t'(N_BINS - 1)) begin
                    tag_last  = 1'b1;
                    bin_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    bin_cnt_d = bin_cnt_q + 1'b1;
                end
            end
        end
    end

    cplx_mag_sq u_mag_sq (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (tag_valid),
        .in_bin    (in_bin),
        .in_idx    (tag_idx),
        .in_first  (tag_first),
        .in_last   (tag_last),
        .out_valid (m_valid),
        .out_mag   (m_mag),
        .out_idx   (m_idx),
        .out_first (m_first),
        .out_last  (m_last)
    );

    // The max is reseeded by the first eligible bin travelling through the
    // pipe, so a new frame never depends on the previous one's leftovers.
    always_comb begin
        seed         = SKIP_DC ? (m_idx == bin_idx_t'(1)) : m_first;
        eligible     = !SKIP_DC || (m_idx != '0);
        max_mag_d    = max_mag_q;
        max_idx_d    = max_idx_q;
        peak_valid_d = 1'b0;
        peak_bin_d   = peak_bin_q;
        peak_mag_d   = peak_mag_q;
        if (m_valid) begin
            if (seed) begin
                max_mag_d = m_mag;
                max_idx_d = m_idx;
            end else if (eligible && (m_mag > max_mag_q)) begin
                max_mag_d = m_mag;
                max_idx_d = m_idx;
            end
            if (m_last) begin
                peak_valid_d = 1'b1;
                peak_bin_d   = max_idx_d;
                peak_mag_d   = max_mag_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            bin_cnt_q    <= '0;
            frame_err_q  <= 1'b0;
            max_mag_q    <= '0;
            max_idx_q    <= '0;
            peak_valid_q <= 1'b0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
        end else begin
            state_q      <= state_d;
            bin_cnt_q    <= bin_cnt_d;
            frame_err_q  <= frame_err_d;
            max_mag_q    <= max_mag_d;
            max_idx_q    <= max_idx_d;
            peak_valid_q <= peak_valid_d;
            peak_bin_q   <= peak_bin_d;
            peak_mag_q   <= peak_mag_d;
        end
    end

    assign bus.peak_valid = peak_valid_q;
    assign bus.peak_bin   = peak_bin_q;
    assign bus.peak_mag   = peak_mag_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_peak_bin_detector.sv
// Directed bench for fft_peak_bin_detector: one DUT with SKIP_DC=0 and one
// with SKIP_DC=1 share the same bin stream; results are collected per cycle
// and compared with hand-computed values.
module tb_fft_peak_bin_detector;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_peak_bin_detector_if bus0 ();
    fft_peak_bin_detector_if bus1 ();

    assign bus1.bin_real  = bus0.bin_real;
    assign bus1.bin_imag  = bus0.bin_imag;
    assign bus1.bin_valid = bus0.bin_valid;
    assign bus1.bin_sof   = bus0.bin_sof;

    fft_peak_bin_detector #(.SKIP_DC(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    fft_peak_bin_detector #(.SKIP_DC(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int total = 0;
    int bad   = 0;

    logic [63:0] ev_bin0[$], ev_mag0[$], ev_cyc0[$], err_cyc0[$];
    logic [63:0] ev_bin1[$], ev_mag1[$];

    logic signed [31:0] fr_re[N_BINS];
    logic signed [31:0] fr_im[N_BINS];
    int last_cyc, sof_cyc;

    always @(negedge clk) begin
        if (reset) begin
            if (bus0.peak_valid) begin
                ev_bin0.push_back(64'(bus0.peak_bin));
                ev_mag0.push_back(bus0.peak_mag);
                ev_cyc0.push_back(64'(cyc));
            end
            if (bus0.frame_err) err_cyc0.push_back(64'(cyc));
            if (bus1.peak_valid) begin
                ev_bin1.push_back(64'(bus1.peak_bin));
                ev_mag1.push_back(bus1.peak_mag);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        ev_bin0.delete(); ev_mag0.delete(); ev_cyc0.delete(); err_cyc0.delete();
        ev_bin1.delete(); ev_mag1.delete();
    endtask

    task automatic fill(input logic signed [31:0] re, input logic signed [31:0] im);
        for (int i = 0; i < N_BINS; i++) begin
            fr_re[i] = re;
            fr_im[i] = im;
        end
    endtask

    task automatic set_bin(input int k, input logic signed [31:0] re, input logic signed [31:0] im);
        fr_re[k] = re;
        fr_im[k] = im;
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus0.bin_valid = 1'b1;
            bus0.bin_sof   = (i == 0);
            bus0.bin_real  = fr_re[i];
            bus0.bin_imag  = fr_im[i];
            if (i == 0) sof_cyc = cyc;
        end
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus0.bin_valid = 1'b0;
            bus0.bin_sof   = 1'b0;
        end
    endtask

    task automatic check_ev0(input string tag, input int i, input logic [63:0] exp_bin,
                             input logic [63:0] exp_mag);
        chk({tag, "_bin"}, (ev_bin0.size() > i) ? ev_bin0[i] : '1, exp_bin);
        chk({tag, "_mag"}, (ev_mag0.size() > i) ? ev_mag0[i] : '1, exp_mag);
    endtask

    task automatic check_ev1(input string tag, input logic [63:0] exp_bin, input logic [63:0] exp_mag);
        chk({tag, "_n1"},   64'(ev_bin1.size()), 64'd1);
        chk({tag, "_bin1"}, (ev_bin1.size() > 0) ? ev_bin1[0] : '1, exp_bin);
        chk({tag, "_mag1"}, (ev_mag1.size() > 0) ? ev_mag1[0] : '1, exp_mag);
    endtask

    int pk[4] = '{31, 0, 16, 1};
    int lastc[4];

    initial begin
        reset          = 1'b0;
        bus0.bin_valid = 1'b0;
        bus0.bin_sof   = 1'b0;
        bus0.bin_real  = '0;
        bus0.bin_imag  = '0;

        // reset held with random traffic
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus0.bin_valid = 1'b1;
            bus0.bin_sof   = 1'($urandom_range(0, 1));
            bus0.bin_real  = $urandom;
            bus0.bin_imag  = $urandom;
            @(negedge clk);
            chk("rst_pv",  64'(bus0.peak_valid), 64'd0);
            chk("rst_bin", 64'(bus0.peak_bin),   64'd0);
            chk("rst_mag", bus0.peak_mag,        64'd0);
            chk("rst_err", 64'(bus0.frame_err),  64'd0);
        end
        @(posedge clk); #1;
        bus0.bin_valid = 1'b0;
        bus0.bin_sof   = 1'b0;
        reset          = 1'b1;
        idle(10);
        chk("post_rst_npk", 64'(ev_bin0.size()),  64'd0);
        chk("post_rst_err", 64'(err_cyc0.size()), 64'd0);

        // single tone
        clear_q();
        fill(1, 1); set_bin(5, 1000, -1000);
        send_beats(N_BINS);
        idle(8);
        chk("tone_n", 64'(ev_bin0.size()), 64'd1);
        check_ev0("tone", 0, 5, 64'd2000000);
        chk("tone_lat", (ev_cyc0.size() > 0) ? ev_cyc0[0] : '1, 64'(last_cyc + 3));
        @(negedge clk);
        chk("tone_hold_bin", 64'(bus0.peak_bin), 64'd5);
        chk("tone_hold_pv",  64'(bus0.peak_valid), 64'd0);

        // most negative sample on both rails
        clear_q();
        fill(1, 1); set_bin(7, 32'h8000_0000, 32'h8000_0000);
        send_beats(N_BINS);
        idle(8);
        check_ev0("ext", 0, 7, 64'h8000_0000_0000_0000);

        // tie resolves to the lower index
        clear_q();
        fill(1, 1); set_bin(3, 10, 0); set_bin(9, 10, 0);
        send_beats(N_BINS);
        idle(8);
        check_ev0("tie", 0, 3, 64'd100);

        // back-to-back frames, no bubbles
        clear_q();
        for (int f = 0; f < 4; f++) begin
            fill(1, 1); set_bin(pk[f], 100, 100);
            send_beats(N_BINS);
            lastc[f] = last_cyc;
        end
        idle(8);
        chk("b2b_n", 64'(ev_bin0.size()), 64'd4);
        for (int f = 0; f < 4; f++) begin
            check_ev0($sformatf("b2b%0d", f), f, 64'(pk[f]), 64'd20000);
            chk($sformatf("b2b%0d_lat", f), (ev_cyc0.size() > f) ? ev_cyc0[f] : '1,
                64'(lastc[f] + 3));
        end
        chk("b2b_gap", (ev_cyc0.size() > 1) ? ev_cyc0[1] - ev_cyc0[0] : '1, 64'd32);

        // DC dominant: SKIP_DC=1 reports the next-largest bin
        clear_q();
        fill(1, 1); set_bin(0, 500, 0); set_bin(20, 30, 40);
        send_beats(N_BINS);
        idle(8);
        check_ev0("dc", 0, 0, 64'd250000);
        check_ev1("dc_skip", 64'd20, 64'd2500);

        // all-zero frame
        clear_q();
        fill(0, 0);
        send_beats(N_BINS);
        idle(8);
        check_ev0("zero", 0, 0, 64'd0);
        check_ev1("zero_skip", 64'd1, 64'd0);

        // sof in the middle of a frame
        clear_q();
        fill(1, 1); set_bin(4, 900, 0);
        send_beats(12);
        fill(1, 1); set_bin(22, 7, 7);
        send_beats(N_BINS);
        idle(8);
        chk("abort_nerr", 64'(err_cyc0.size()), 64'd1);
        chk("abort_errcyc", (err_cyc0.size() > 0) ? err_cyc0[0] : '1, 64'(sof_cyc + 1));
        chk("abort_n", 64'(ev_bin0.size()), 64'd1);
        check_ev0("abort", 0, 22, 64'd98);

        // stray beat while idle
        clear_q();
        @(posedge clk); #1;
        bus0.bin_valid = 1'b1;
        bus0.bin_sof   = 1'b0;
        bus0.bin_real  = 5000;
        bus0.bin_imag  = 5000;
        idle(3);
        chk("stray_nerr", 64'(err_cyc0.size()), 64'd1);
        fill(1, 1); set_bin(2, 3, 0);
        send_beats(N_BINS);
        idle(8);
        chk("stray_n", 64'(ev_bin0.size()), 64'd1);
        check_ev0("stray", 0, 2, 64'd9);
        chk("stray_nerr2", 64'(err_cyc0.size()), 64'd1);

        // reset mid-frame
        clear_q();
        fill(1, 1); set_bin(10, 1000, 0);
        send_beats(20);
        @(posedge clk); #1;
        reset          = 1'b0;
        bus0.bin_valid = 1'b0;
        bus0.bin_sof   = 1'b0;
        @(negedge clk);
        chk("mid_rst_bin", 64'(bus0.peak_bin), 64'd0);
        chk("mid_rst_mag", bus0.peak_mag, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        fill(1, 1); set_bin(25, 50, 0);
        send_beats(N_BINS);
        idle(8);
        chk("mid_rst_n", 64'(ev_bin0.size()), 64'd1);
        check_ev0("mid_rst", 0, 25, 64'd2500);
        chk("mid_rst_nerr", 64'(err_cyc0.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
